// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   EX->MEM pipeline register with a two-entry skid buffer.
//   - Captures the Execute results: ALU result, zero flag, store data, branch target,
//     destination register and MEM/WB control bits.
//   - Presents them to the Memory stage.
//   - Resolves the branch (pcsrc) from the registered head entry.
//   - in_ready comes straight from a flop, so no combinational path runs from
//     out_ready back into Execute.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
//   - Once out_valid is high, it and the out_* payload stay stable until out_ready is seen.
//   - in_valid may be raised at any time. The input is only taken when in_ready is high.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  Execute-side handshake (in_ready registered)
//   in_alu_result, in_zero, in_store_data, in_br_target, in_wreg, in_ctrl
//                        Execute payload; in_ctrl = {reg_write, mem_to_reg, mem_read,
//                        mem_write, branch}
//   flush                drop every held entry and any same-cycle input
//   out_valid / out_ready  Memory-side handshake
//   out_*                head entry payload, same order as the inputs
//   pcsrc                out_valid & branch & zero of the head entry
module ex_mem_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic                  in_zero,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic [DATA_W-1:0]     in_br_target,
  input  logic [REG_ADDR_W-1:0] in_wreg,
  input  logic [4:0]            in_ctrl,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic                  out_zero,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [DATA_W-1:0]     out_br_target,
  output logic [REG_ADDR_W-1:0] out_wreg,
  output logic [4:0]            out_ctrl,
  output logic                  pcsrc
);

  localparam int PW = 3 * DATA_W + REG_ADDR_W + 6;

  // EMPTY: H,S invalid.  ONE: H valid.  FULL: H and S valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [PW-1:0] h_q, h_d;
  logic [PW-1:0] s_q, s_d;
  logic [PW-1:0] in_pl;
  logic          accept;
  logic          pop;
  logic          load_h_in;
  logic          load_h_s;
  logic          load_s_in;

  assign in_pl  = {in_alu_result, in_zero, in_store_data, in_br_target, in_wreg, in_ctrl};
  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic, including which payload register captures this cycle
  always_comb begin
    state_d   = state_q;
    load_h_in = 1'b0;
    load_h_s  = 1'b0;
    load_s_in = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_h_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_h_in = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_s_in = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so accept cannot occur
        if (pop) begin
          state_d  = ST_ONE;
          load_h_s = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything. The pop still completes on the Memory side,
    // and any input offered in the same cycle is dropped.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_h_in = 1'b0;
      load_h_s  = 1'b0;
      load_s_in = 1'b0;
    end
    // Registered form of ~S.valid for the next cycle
    in_ready_d = (state_d != ST_FULL);
  end

  // Output logic
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = in_ready_q;
    {out_alu_result, out_zero, out_store_data, out_br_target, out_wreg, out_ctrl} = h_q;
    pcsrc     = out_valid & out_ctrl[0] & out_zero;
  end

  // Payload datapath: registers only change on a capture, never on pop or flush
  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (load_h_in) h_d = in_pl;
    if (load_h_s)  h_d = s_q;
    if (load_s_in) s_d = in_pl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      s_q <= '0;
    end else begin
      h_q <= h_d;
      s_q <= s_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg.
// The reference model is a two-deep FIFO held in a queue:
//   - in_ready is expected whenever fewer than two entries are held.
//   - out_valid is expected whenever the queue is non-empty.
//   - The out_* payload is expected to equal the queue front.
//   - flush empties the queue.
module tb_ex_mem_skid_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 3 * DW + AW + 6;
  localparam int ZB = 2 * DW + AW + 5;  // zero-flag bit inside a packed payload

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_alu_result;
  logic          in_zero;
  logic [DW-1:0] in_store_data;
  logic [DW-1:0] in_br_target;
  logic [AW-1:0] in_wreg;
  logic [4:0]    in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu_result;
  logic          out_zero;
  logic [DW-1:0] out_store_data;
  logic [DW-1:0] out_br_target;
  logic [AW-1:0] out_wreg;
  logic [4:0]    out_ctrl;
  logic          pcsrc;
  logic [PW-1:0] out_pl;

  int            n_checks;
  int            n_fail;
  logic [PW-1:0] exp_q[$];

  assign out_pl = {out_alu_result, out_zero, out_store_data, out_br_target, out_wreg, out_ctrl};

  ex_mem_skid_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_zero        (in_zero),
    .in_store_data  (in_store_data),
    .in_br_target   (in_br_target),
    .in_wreg        (in_wreg),
    .in_ctrl        (in_ctrl),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_zero       (out_zero),
    .out_store_data (out_store_data),
    .out_br_target  (out_br_target),
    .out_wreg       (out_wreg),
    .out_ctrl       (out_ctrl),
    .pcsrc          (pcsrc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pl(input logic [DW-1:0] alu, input logic zero,
                                          input logic [DW-1:0] st, input logic [DW-1:0] br,
                                          input logic [AW-1:0] wreg, input logic [4:0] ctrl);
    return {alu, zero, st, br, wreg, ctrl};
  endfunction

  function automatic logic [PW-1:0] rand_pl();
    return mk_pl($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 AW'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endfunction

  // Scoreboard comparison of all outputs against the FIFO model
  task automatic check_outputs();
    logic [PW-1:0] h;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("out_payload", out_pl, h);
      check("pcsrc", pcsrc, h[0] & h[ZB]);
    end else begin
      check("pcsrc_idle", pcsrc, 1'b0);
    end
  endtask

  // Driver: apply one cycle of stimulus, advance the model at the edge, then check
  task automatic step(input logic v, input logic [PW-1:0] pl, input logic ordy, input logic fl);
    logic acc;
    logic pp;
    @(negedge clk);
    in_valid = v;
    {in_alu_result, in_zero, in_store_data, in_br_target, in_wreg, in_ctrl} = pl;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = v && (exp_q.size() < 2);
    pp  = ordy && (exp_q.size() > 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pl);
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_pcsrc"}, pcsrc, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_alu"}, out_alu_result, '0);
    check({tag, "_out_payload"}, out_pl, '0);
  endtask

  // Asynchronous reset applied mid-cycle, away from any clock edge
  task automatic async_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] p;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush    = 1'b0;
    {in_alu_result, in_zero, in_store_data, in_br_target, in_wreg, in_ctrl} = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with one-cycle latency
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, mk_pl(DW'(i), 1'b0, DW'(i * 16), DW'(i * 4), AW'(i), 5'b10000), 1'b1, 1'b0);
      check("stream_data", out_alu_result, DW'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Stall: the second entry lands in the skid register, then both drain in order
    step(1'b1, mk_pl(32'hA, 1'b0, 32'h0, 32'h0, 5'd1, 5'b10000), 1'b0, 1'b0);
    step(1'b1, mk_pl(32'hB, 1'b0, 32'h0, 32'h0, 5'd2, 5'b10000), 1'b0, 1'b0);
    check("stall_in_ready", in_ready, 1'b0);
    step(1'b1, rand_pl(), 1'b0, 1'b0);  // offered while full, must be ignored
    step(1'b0, '0, 1'b1, 1'b0);
    check("stall_second", out_alu_result, 32'hB);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Branch resolution
    step(1'b1, mk_pl(32'h0, 1'b1, 32'h0, 32'h40, 5'd0, 5'b00001), 1'b1, 1'b0);
    check("branch_taken", pcsrc, 1'b1);
    check("branch_target", out_br_target, 32'h40);
    step(1'b1, mk_pl(32'h5, 1'b0, 32'h0, 32'h40, 5'd0, 5'b00001), 1'b1, 1'b0);
    check("branch_not_taken", pcsrc, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a same-cycle input
    step(1'b1, rand_pl(), 1'b0, 1'b0);
    step(1'b1, rand_pl(), 1'b0, 1'b0);
    step(1'b1, mk_pl(32'hDEAD, 1'b1, 32'h0, 32'h0, 5'd3, 5'b00001), 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of a full buffer
    step(1'b1, rand_pl(), 1'b0, 1'b0);
    step(1'b1, rand_pl(), 1'b0, 1'b0);
    async_reset();
    step(1'b1, mk_pl(32'h77, 1'b0, 32'h1, 32'h2, 5'd4, 5'b11000), 1'b0, 1'b0);
    check("post_reset_load", out_alu_result, 32'h77);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      p = rand_pl();
      step(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
